// File: rtl/isw_pkg.sv
// Shared constants and index helpers for the ISW masked-AND pipeline.
// Pair indices are lexicographic over (i,j) with i<j.
package isw_pkg;

    localparam int ISW_LATENCY = 32'sd3;

    function automatic int nr_of(input int n);
        return (n * (n - 32'sd1)) / 32'sd2;
    endfunction

    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 32'sd1)) / 32'sd2 + (j - i - 32'sd1);
    endfunction

endpackage

// File: rtl/and_isw_pipe_reg.sv
// Single pipeline register with synchronous clear and load enable.
// Every product and randomness term gets its own instance.
module and_isw_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority; otherwise load only on enabled edges
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/and_isw_pipe.sv
// Three-stage ISW masked AND of N = ORDER+1 shares, WIDTH parallel lanes.
// Cross products are only combined after the randomised term is registered.
module and_isw_pipe
    import isw_pkg::*;
#(
    parameter int ORDER = 1,
    parameter int WIDTH = 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           port_en,
    input  logic                                           port_valid_in,
    input  logic [(ORDER+32'sd1)*WIDTH-32'sd1:0]           port_a,
    input  logic [(ORDER+32'sd1)*WIDTH-32'sd1:0]           port_b,
    input  logic [nr_of(ORDER+32'sd1)*WIDTH-32'sd1:0]      port_r,
    output logic                                           port_valid_out,
    output logic [(ORDER+32'sd1)*WIDTH-32'sd1:0]           port_c
);

    localparam int N  = ORDER + 32'sd1;
    localparam int NR = nr_of(N);

    logic [WIDTH-1:0] p1_r     [N];
    logic [WIDTH-1:0] p2_r     [N];
    logic [WIDTH-1:0] u1_r     [NR];
    logic [WIDTH-1:0] v1_r     [NR];
    logic [WIDTH-1:0] rc1_r    [NR];
    logic [WIDTH-1:0] z2_r     [NR];
    logic [WIDTH-1:0] rc2_r    [NR];
    logic [WIDTH-1:0] term_s   [N][N];
    logic [WIDTH-1:0] c_next_s [N];
    logic [0:0]       vld_r    [ISW_LATENCY];

    for (genvar i = 32'sd0; i < N; i++) begin : g_share
        and_isw_pipe_reg #(.WIDTH(WIDTH)) u_p1 (
            .clk(clk), .reset(reset), .en(port_en),
            .d(port_a[i*WIDTH +: WIDTH] & port_b[i*WIDTH +: WIDTH]), .q(p1_r[i]));
        and_isw_pipe_reg #(.WIDTH(WIDTH)) u_p2 (
            .clk(clk), .reset(reset), .en(port_en), .d(p1_r[i]), .q(p2_r[i]));
        and_isw_pipe_reg #(.WIDTH(WIDTH)) u_c3 (
            .clk(clk), .reset(reset), .en(port_en),
            .d(c_next_s[i]), .q(port_c[i*WIDTH +: WIDTH]));

        for (genvar j = 32'sd0; j < N; j++) begin : g_col
            if (j > i) begin : g_up
                localparam int K = pair_idx(i, j, N);
                logic [WIDTH-1:0] r_s;
                assign r_s = port_r[K*WIDTH +: WIDTH];

                // Randomness is folded into a_i&b_j before anything else touches it
                and_isw_pipe_reg #(.WIDTH(WIDTH)) u_u1 (
                    .clk(clk), .reset(reset), .en(port_en),
                    .d(r_s ^ (port_a[i*WIDTH +: WIDTH] & port_b[j*WIDTH +: WIDTH])),
                    .q(u1_r[K]));
                and_isw_pipe_reg #(.WIDTH(WIDTH)) u_v1 (
                    .clk(clk), .reset(reset), .en(port_en),
                    .d(port_a[j*WIDTH +: WIDTH] & port_b[i*WIDTH +: WIDTH]), .q(v1_r[K]));
                and_isw_pipe_reg #(.WIDTH(WIDTH)) u_rc1 (
                    .clk(clk), .reset(reset), .en(port_en), .d(r_s), .q(rc1_r[K]));
                and_isw_pipe_reg #(.WIDTH(WIDTH)) u_z2 (
                    .clk(clk), .reset(reset), .en(port_en),
                    .d(u1_r[K] ^ v1_r[K]), .q(z2_r[K]));
                and_isw_pipe_reg #(.WIDTH(WIDTH)) u_rc2 (
                    .clk(clk), .reset(reset), .en(port_en), .d(rc1_r[K]), .q(rc2_r[K]));

                assign term_s[i][j] = rc2_r[K];
            end else if (j < i) begin : g_lo
                assign term_s[i][j] = z2_r[pair_idx(j, i, N)];
            end else begin : g_diag
                assign term_s[i][j] = {WIDTH{1'b0}};
            end
        end
    end

    // Stage-3 recombination: own product plus one term per partner share
    always_comb begin
        for (int i = 32'sd0; i < N; i++) begin
            c_next_s[i] = p2_r[i];
            for (int j = 32'sd0; j < N; j++) begin
                c_next_s[i] = c_next_s[i] ^ term_s[i][j];
            end
        end
    end

    for (genvar s = 32'sd0; s < ISW_LATENCY; s++) begin : g_vld
        logic [0:0] vld_d_s;
        if (s == 32'sd0) begin : g_head
            assign vld_d_s = port_valid_in;
        end else begin : g_tail
            assign vld_d_s = vld_r[s-32'sd1];
        end
        and_isw_pipe_reg #(.WIDTH(1)) u_vld (
            .clk(clk), .reset(reset), .en(port_en), .d(vld_d_s), .q(vld_r[s]));
    end

    assign port_valid_out = vld_r[ISW_LATENCY-32'sd1];

endmodule

// File: tb/tb_and_isw_pipe.sv
// Randomised and directed bench for and_isw_pipe (ORDER=1/WIDTH=1 and ORDER=2/WIDTH=4).
// Expected results come from unmasking the operands: c = (xor a_i) & (xor b_i).
module tb_and_isw_pipe;

    typedef struct {
        bit         v;
        logic [3:0] c;
        bit         z;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_s, en1_s, vi1_s, vo1_s;
    logic [1:0]  a1_s, b1_s, c1_s;
    logic [0:0]  r1_s;
    logic        rst2_s, en2_s, vi2_s, vo2_s;
    logic [11:0] a2_s, b2_s, r2_s, c2_s;

    int   chk_cnt = 0;
    int   err_cnt = 0;
    ent_t q1[$];
    ent_t q2[$];
    ent_t cur1, cur2;

    and_isw_pipe #(.ORDER(1), .WIDTH(1)) dut1 (
        .clk(clk), .reset(rst1_s), .port_en(en1_s), .port_valid_in(vi1_s),
        .port_a(a1_s), .port_b(b1_s), .port_r(r1_s),
        .port_valid_out(vo1_s), .port_c(c1_s));

    and_isw_pipe #(.ORDER(2), .WIDTH(4)) dut2 (
        .clk(clk), .reset(rst2_s), .port_en(en2_s), .port_valid_in(vi2_s),
        .port_a(a2_s), .port_b(b2_s), .port_r(r2_s),
        .port_valid_out(vo2_s), .port_c(c2_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] unmask(input logic [11:0] x, input int n, input int w);
        logic [3:0]  m;
        logic [11:0] t;
        m = 4'b0000;
        for (int i = 0; i < n; i++) begin
            t = x >> (i * w);
            m = m ^ (t[3:0] & ((w == 1) ? 4'b0001 : 4'b1111));
        end
        return m;
    endfunction

    function automatic ent_t zent();
        ent_t e;
        e.v = 1'b0;
        e.c = 4'b0000;
        e.z = 1'b1;
        return e;
    endfunction

    // One clock on the selected DUT (other one held), then model update and checks
    task automatic cyc(input int sel, input bit rst, input bit en, input bit v,
                       input logic [11:0] a, input logic [11:0] b, input logic [11:0] r);
        ent_t        e, cur;
        int          n, w;
        logic [11:0] c_obs;
        logic        vo;
        string       pfx;
        if (sel == 1) begin
            rst1_s = rst; en1_s = en; vi1_s = v;
            a1_s = a[1:0]; b1_s = b[1:0]; r1_s = r[0:0];
            rst2_s = 1'b0; en2_s = 1'b0;
            n = 2; w = 1; pfx = "d1";
        end else begin
            rst2_s = rst; en2_s = en; vi2_s = v;
            a2_s = a; b2_s = b; r2_s = r;
            rst1_s = 1'b0; en1_s = 1'b0;
            n = 3; w = 4; pfx = "d2";
        end
        @(posedge clk);
        e.v = v;
        e.c = unmask(a, n, w) & unmask(b, n, w);
        e.z = 1'b0;
        if (sel == 1) begin
            if (rst) begin
                q1.delete(); q1.push_back(zent()); q1.push_back(zent()); cur1 = zent();
            end else if (en) begin
                q1.push_back(e); cur1 = q1.pop_front();
            end
            cur = cur1;
        end else begin
            if (rst) begin
                q2.delete(); q2.push_back(zent()); q2.push_back(zent()); cur2 = zent();
            end else if (en) begin
                q2.push_back(e); cur2 = q2.pop_front();
            end
            cur = cur2;
        end
        @(negedge clk);
        if (sel == 1) begin
            vo = vo1_s; c_obs = {10'b0, c1_s};
        end else begin
            vo = vo2_s; c_obs = c2_s;
        end
        chk({pfx, "_valid"}, vo, cur.v);
        chk({pfx, "_unmasked"}, unmask(c_obs, n, w), cur.c);
        if (cur.z) chk({pfx, "_zero"}, c_obs, 32'd0);
    endtask

    function automatic logic [11:0] rnd();
        return 12'($urandom());
    endfunction

    logic [11:0] held_c;
    logic        held_v;
    logic [11:0] xa, xb, xr;
    logic [8:0]  cmb;

    initial begin
        rst1_s = 1'b0; en1_s = 1'b0; vi1_s = 1'b0; a1_s = '0; b1_s = '0; r1_s = '0;
        rst2_s = 1'b0; en2_s = 1'b0; vi2_s = 1'b0; a2_s = '0; b2_s = '0; r2_s = '0;
        @(negedge clk);

        // Reset both; dut2 with enable low to show reset wins
        cyc(1, 1'b1, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(2, 1'b1, 1'b0, 1'b1, rnd(), rnd(), rnd());
        cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);

        // a=(1,0), b=(0,1): r=1 gives c=(1,0), r=0 gives c=(0,1)
        cyc(1, 1'b0, 1'b1, 1'b1, 12'h1, 12'h2, 12'h1);
        cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        chk("d1_shares_r1", c1_s, 32'h1);
        cyc(1, 1'b0, 1'b1, 1'b1, 12'h1, 12'h2, 12'h0);
        cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        chk("d1_shares_r0", c1_s, 32'h2);

        // Exhaustive ORDER=1: every share pattern and random bit
        for (int idx = 0; idx < 32; idx++) begin
            cyc(1, 1'b0, 1'b1, 1'b1, 12'(idx & 3), 12'((idx >> 2) & 3), 12'((idx >> 4) & 1));
        end

        // Reset one cycle after an op: nothing partial emerges
        cyc(1, 1'b0, 1'b1, 1'b1, 12'h1, 12'h1, 12'h0);
        cyc(1, 1'b1, 1'b1, 1'b1, 12'h3, 12'h1, 12'h1);
        for (int k = 0; k < 3; k++) cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(1, 1'b0, 1'b1, 1'b1, 12'h2, 12'h2, 12'h1);
        for (int k = 0; k < 3; k++) cyc(1, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);

        // Stall: two ops, five frozen cycles with junk inputs, third op
        cyc(2, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(2, 1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd());
        cyc(2, 1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd());
        held_c = c2_s;
        held_v = vo2_s;
        for (int k = 0; k < 5; k++) begin
            cyc(2, 1'b0, 1'b0, 1'b1, rnd(), rnd(), rnd());
            chk("d2_stall_c", c2_s, held_c);
            chk("d2_stall_v", vo2_s, held_v);
        end
        cyc(2, 1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd());
        cyc(2, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(2, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);

        // Back-to-back random operations, mostly valid
        for (int k = 0; k < 1000; k++) begin
            cyc(2, 1'b0, 1'b1, ($urandom_range(0, 7) != 0), rnd(), rnd(), rnd());
        end

        // Exhaustive ORDER=2: four combinations per op, one per lane
        for (int idx = 0; idx < 128; idx++) begin
            xa = 12'h0; xb = 12'h0; xr = 12'h0;
            for (int l = 0; l < 4; l++) begin
                cmb = 9'(idx * 4 + l);
                for (int s = 0; s < 3; s++) begin
                    xa[s*4+l] = cmb[s];
                    xb[s*4+l] = cmb[3+s];
                    xr[s*4+l] = cmb[6+s];
                end
            end
            cyc(2, 1'b0, 1'b1, 1'b1, xa, xb, xr);
        end

        // Enable toggling mid-stream
        for (int k = 0; k < 300; k++) begin
            cyc(2, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd(), rnd(), rnd());
        end

        // Reset mid-stream on the wide instance, then recover
        cyc(2, 1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd());
        cyc(2, 1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd());
        for (int k = 0; k < 3; k++) cyc(2, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
        cyc(2, 1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd());
        for (int k = 0; k < 3; k++) cyc(2, 1'b0, 1'b1, 1'b0, 12'h0, 12'h0, 12'h0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/and_isw_pipe.md
AND_ISW_PIPE -- requirements
Module: and_isw_pipe

Interface
REQ-001 The block SHALL have parameter ORDER, default 1, masking order d; the share count is N = ORDER+1; legal range 1..4.
REQ-002 The block SHALL have parameter WIDTH, default 1, bits per share; each bit is an independent, bitwise-parallel gadget lane.
REQ-003 The block SHALL have port clk, input, 1: single clock; every register updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port port_en, input, 1: pipeline advance enable; when 0, every register holds its value.
REQ-006 The block SHALL have port port_valid_in, input, 1: the operand and randomness shares on this cycle are a valid operation.
REQ-007 The block SHALL have port port_a, input, N*WIDTH: shares of operand a; share i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port port_b, input, N*WIDTH: shares of operand b, packed like port_a.
REQ-009 The block SHALL have port port_r, input, NR*WIDTH, where NR = N*(N-1)/2: fresh randomness, one WIDTH slice per share pair (i,j) with i<j.
REQ-010 The block SHALL have port port_valid_out, output, 1: port_c holds a valid result.
REQ-011 The block SHALL have port port_c, output, N*WIDTH: shares of c = a AND b, packed like port_a.

Function
REQ-012 The pair index k(i,j) for i<j SHALL be assigned lexicographically: (0,1)=0, (0,2)=1, ..., (0,N-1), (1,2), ..., (N-2,N-1).
REQ-013 Stage 1 SHALL register p_i = a_i&b_i for every i.
REQ-014 For every pair i<j, stage 1 SHALL register u_ij = r_k XOR (a_i&b_j), v_ij = a_j&b_i, and a copy of r_k, as separate registers.
REQ-015 No cross product SHALL be XORed with another cross product before the r_k XOR has itself been registered (the glitch barrier).
REQ-016 Stage 2 SHALL register z_ij = u_ij XOR v_ij for every pair i<j, and SHALL forward p_i and r_k unchanged through a register.
REQ-017 Stage 3 SHALL register port_c share i = p_i XOR (XOR over j>i of r_k(i,j)) XOR (XOR over j<i of z_ji).
REQ-018 Latency SHALL be exactly 3 enabled cycles: an operation sampled on enabled edge t appears on port_c/port_valid_out after enabled edge t+2, counting edge t as the first.
REQ-019 Throughput SHALL be one operation per enabled cycle, with no bubbles inserted.
REQ-020 The valid flag SHALL travel through a 3-deep shift register that advances only when port_en=1.
REQ-021 port_valid_out SHALL equal the stage-3 valid bit.
REQ-022 port_c SHALL update on enabled cycles even when the valid bit is 0; consumers qualify it with port_valid_out.
REQ-023 Correctness invariant: the XOR over i of port_c share i SHALL equal (XOR over i of a_i) AND (XOR over i of b_i), for any port_r value.
REQ-024 When port_en=0, port_c, port_valid_out and all internal registers SHALL hold; the inputs on that cycle SHALL be ignored.
REQ-025 When port_en toggles mid-stream, no operation SHALL be lost or duplicated.

Reset
REQ-026 While reset=1 at a clock edge, every register SHALL be cleared to 0, including data, randomness copies and valid bits, regardless of port_en.
REQ-027 On the first clock after reset deasserts, port_valid_out SHALL be 0 and port_c SHALL be all-zero.
REQ-028 In-flight operations SHALL be discarded on reset, with no partial output.
REQ-029 Reset SHALL take priority over port_en.

Structure
REQ-030 A shared package isw_pkg SHALL hold: the NR computation function, the pair-index function k(i,j), and the latency constant ISW_LATENCY = 3.
REQ-031 One sub-module SHALL be used: and_isw_pipe_reg, a WIDTH-bit register with synchronous reset and enable.
REQ-032 Every pipeline register SHALL be an instance of and_isw_pipe_reg, so each product/random term is a distinct register (for the glitch model).
REQ-033 No logic SHALL sit between stage-3 registers and outputs.

Verification
REQ-034 Scenario ORDER=1, WIDTH=1: a=(1,0), b=(0,1), r=1, valid_in=1, en=1 -> after 3 edges valid_out=1, port_c=(1,0); unmasked result 1.
REQ-035 Scenario ORDER=1: same a and b, sweep r=0 and r=1 -> unmasked c=1 both times; r=0 gives port_c=(0,1).
REQ-036 Scenario ORDER=2, WIDTH=4: 1000 random operations back-to-back with random r -> unmasked c equals a&b every cycle; valid_out is the input valid stream delayed by 3.
REQ-037 Scenario stall: issue 3 ops; hold en=0 for 5 cycles after the 2nd op -> outputs frozen during the stall; all 3 results emerge in order, none duplicated.
REQ-038 Scenario reset: reset=1 one cycle after issuing an op -> valid_out=0 and port_c=0 on the next 3 cycles; an op issued after reset completes correctly.
REQ-039 Scenario exhaustive: ORDER=1 and ORDER=2, WIDTH=1, all share combinations and all port_r values -> invariant REQ-023 holds.
